bm_load_ctrl: RTL and testbench

//  Sequences a bitmap load: fetches BM_WORDS consecutive 16-bit words from data memory,

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/bm_load_ctrl_if.sv | 27 ++
 rtl/bm_word_packer.sv | 24 ++
 rtl/bm_load_ctrl.sv | 144 ++++++++++++++
 tb/tb_bm_load_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared sizes and state encoding for the bitmap load controller.
package cpu_pkg;

    localparam int WORD_W   = 16;
    localparam int BM_W     = 1536;
    localparam int BM_WORDS = 96;
    localparam int ADDR_W   = 16;
    localparam int IDX_W    = 7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        COMMIT = 3'd3,
        DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/bm_load_ctrl_if.sv
// Memory read bus plus the shared bitmap write port of the register file.
interface bm_load_ctrl_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;
    logic              cpu_wbm;
    logic [1:0]        cpu_wbm_addr;
    logic [BM_W-1:0]   cpu_wbm_data;
    logic              wbm;
    logic [1:0]        wbm_addr;
    logic [BM_W-1:0]   wbm_data;

    modport master (
        output mem_req, mem_addr, wbm, wbm_addr, wbm_data,
        input  mem_gnt, mem_rvalid, mem_rdata, cpu_wbm, cpu_wbm_addr, cpu_wbm_data
    );

    modport slave (
        input  mem_req, mem_addr, wbm, wbm_addr, wbm_data,
        output mem_gnt, mem_rvalid, mem_rdata, cpu_wbm, cpu_wbm_addr, cpu_wbm_data
    );

endinterface

// File: rtl/bm_word_packer.sv
// Bitmap assembly buffer: word idx lands in img[16*idx +: 16], word 0 in the LSBs.
module bm_word_packer
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WORD_W-1:0] word,
    output logic [BM_W-1:0]  img
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img <= '0;
        end else if (clr) begin
            img <= '0;
        end else if (we && (idx <= LAST_IDX)) begin
            img[WORD_W*int'(idx) +: WORD_W] <= word;
        end
    end

endmodule

// File: rtl/bm_load_ctrl.sv
// Bitmap load sequencer and bitmap write-port arbiter (CPU writeback has priority).
// Optional BM_LOAD_ABORT_EN adds abort/aborted and the DRAIN state.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | mem_req high for word <count> at mem_addr
// WAIT   | granted, waiting for mem_rvalid
// COMMIT | image complete, writing it when the CPU leaves the port free
// DRAIN  | aborted while a read was outstanding; swallowing its data
module bm_load_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        dst_bm,
    output logic              busy,
    output logic              done,
    bm_load_ctrl_if.master    bus
`ifdef BM_LOAD_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        dst_q;
    logic              done_q;
    logic [BM_W-1:0]   img;
    logic              abort_req;
    logic              load_go;
    logic              word_hit;
    logic              commit_wr;

`ifdef BM_LOAD_ABORT_EN
    logic aborted_q;
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    assign load_go   = (state == IDLE) && start;
    assign word_hit  = (state == WAIT) && bus.mem_rvalid;
    assign commit_wr = (state == COMMIT) && !bus.cpu_wbm && !abort_req;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign bus.mem_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        bus.mem_req      = 1'b0;
        bus.wbm          = bus.cpu_wbm;
        bus.wbm_addr     = bus.cpu_wbm_addr;
        bus.wbm_data     = bus.cpu_wbm_data;
        case (state)
            IDLE: begin
                if (start) state_nx = REQ;
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (abort_req)        state_nx = IDLE;
                else if (bus.mem_gnt) state_nx = WAIT;
            end
            WAIT: begin
                // Abort coinciding with the data beat needs no drain.
                if (bus.mem_rvalid) begin
                    if (abort_req)              state_nx = IDLE;
                    else if (count == LAST_IDX) state_nx = COMMIT;
                    else                        state_nx = REQ;
                end else if (abort_req) begin
                    state_nx = DRAIN;
                end
            end
            COMMIT: begin
                if (abort_req) begin
                    state_nx = IDLE;
                end else if (!bus.cpu_wbm) begin
                    state_nx     = IDLE;
                    bus.wbm      = 1'b1;
                    bus.wbm_addr = dst_q;
                    bus.wbm_data = img;
                end
            end
            DRAIN: begin
                if (bus.mem_rvalid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            addr   <= '0;
            dst_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit_wr;
            if (load_go) begin
                count <= '0;
                addr  <= base_addr;
                dst_q <= dst_bm;
            end else if (word_hit) begin
                count <= count + 1'b1;
                addr  <= addr + 1'b1;
            end
        end
    end

`ifdef BM_LOAD_ABORT_EN
    // Any return to IDLE other than the commit write is an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= (state != IDLE) && (state_nx == IDLE) && !commit_wr;
        end
    end
`endif

    bm_word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_go),
        .we    (word_hit && !abort_req),
        .idx   (count),
        .word  (bus.mem_rdata),
        .img   (img)
    );

endmodule

// File: tb/tb_bm_load_ctrl.sv
// Directed bench for bm_load_ctrl: memory responder, CPU writeback driver, write-port monitor.
module tb_bm_load_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [1:0]  dst_bm = '0;
    logic        busy, done;
`ifdef BM_LOAD_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    bm_load_ctrl_if bus();

    bm_load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .dst_bm    (dst_bm),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
`ifdef BM_LOAD_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // responder / monitor state
    int          gnt_max = 0, rv_max = 0;
    logic [15:0] base_ref = '0;
    int          gnt_cnt = 0, rv_cnt = 0;
    bit          pend = 0;
    logic [15:0] pend_addr = '0;
    int          k_gnt = 0, k_rv = 0;
    int          addr_err = 0, stab_err = 0;
    logic [15:0] addr_log [96];
    bit          prev_req = 0, prev_gnt = 0;
    logic [15:0] prev_addr = '0;
    bit          cpu_hold_en = 0;
    int          cpu_left = 0;
    int          ncyc = 0, commit_entry = 0;
    int          abort_at = -1;
    bit          abort_pending = 0;
    int          wbm_cnt = 0, ld_commits = 0, cpu_ok = 0, cpu_bad = 0, cap_t = -1;
    int          done_cnt = 0, aborted_cnt = 0;
    logic [1:0]  cap_addr = '0;
    logic [BM_W-1:0] cap_img = '0;
    logic [BM_W-1:0] cpu_pat;

    initial begin
        cpu_pat          = {96{16'hA5C3}};
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        bus.cpu_wbm      = 1'b0;
        bus.cpu_wbm_addr = 2'd1;
        bus.cpu_wbm_data = cpu_pat;
        forever begin
            @(negedge clk);
            ncyc++;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
`ifdef BM_LOAD_ABORT_EN
            abort = 1'b0;
`endif
            if (!rst_n) begin
                pend     = 0;
                gnt_cnt  = 0;
                prev_req = 0;
                cpu_left = 0;
                bus.cpu_wbm = 1'b0;
            end else begin
                if (prev_req && !prev_gnt && bus.mem_req && (bus.mem_addr !== prev_addr))
                    stab_err++;
                if (cpu_left > 0) begin
                    bus.cpu_wbm = 1'b1;
                    cpu_left--;
                end else begin
                    bus.cpu_wbm = 1'b0;
                end
                if (abort_pending) begin
`ifdef BM_LOAD_ABORT_EN
                    abort = 1'b1;
`endif
                    abort_pending = 0;
                end
                if (pend) begin
                    if (rv_cnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = pend_addr - base_ref;
                        pend    = 0;
                        k_rv++;
                        gnt_cnt = int'($urandom_range(gnt_max, 0));
                        if (k_rv == 96) begin
                            commit_entry = ncyc + 1;
                            if (cpu_hold_en) cpu_left = 5;
                        end
                    end else begin
                        rv_cnt--;
                    end
                end else if (bus.mem_req) begin
                    if (gnt_cnt == 0) begin
                        bus.mem_gnt = 1'b1;
                        pend_addr   = bus.mem_addr;
                        if (k_gnt < 96) addr_log[k_gnt] = bus.mem_addr;
                        if (bus.mem_addr !== base_ref + 16'(k_gnt)) addr_err++;
                        rv_cnt = int'($urandom_range(rv_max, 0));
                        if (k_gnt == abort_at) begin
                            rv_cnt = 3;
                            abort_pending = 1;
                        end
                        pend = 1;
                        k_gnt++;
                    end else begin
                        gnt_cnt--;
                    end
                end
                prev_req  = bus.mem_req;
                prev_gnt  = bus.mem_gnt;
                prev_addr = bus.mem_addr;
            end
            #1;
            if (bus.wbm) begin
                wbm_cnt++;
                if (bus.cpu_wbm) begin
                    if (bus.wbm_addr === 2'd1 && bus.wbm_data === cpu_pat) cpu_ok++;
                    else cpu_bad++;
                end else begin
                    ld_commits++;
                    cap_addr = bus.wbm_addr;
                    cap_img  = bus.wbm_data;
                    cap_t    = ncyc - commit_entry;
                end
            end
            if (done) done_cnt++;
`ifdef BM_LOAD_ABORT_EN
            if (aborted) aborted_cnt++;
`endif
        end
    end

    task automatic clear_counts();
        k_gnt = 0; k_rv = 0; addr_err = 0; stab_err = 0;
        wbm_cnt = 0; ld_commits = 0; cpu_ok = 0; cpu_bad = 0; cap_t = -1;
        done_cnt = 0; aborted_cnt = 0; gnt_cnt = 0;
    endtask

    task automatic run_load(input logic [15:0] base, input logic [1:0] dst, input int gmax,
                            input int rmax, input bit hold, input bit spurious, output int cyc);
        base_ref = base; gnt_max = gmax; rv_max = rmax; cpu_hold_en = hold;
        clear_counts();
        @(negedge clk);
        start = 1'b1; base_addr = base; dst_bm = dst;
        @(negedge clk);
        cyc = 1;
        chk("busy_after_start", busy, 1);
        if (spurious) begin
            base_addr = 16'h7000;
            dst_bm    = ~dst;
        end else begin
            start = 1'b0;
        end
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (spurious) begin
                if (cyc == 2)   start = 1'b0;
                if (cyc == 100) begin start = 1'b1; base_addr = 16'h7777; end
                if (cyc == 101) start = 1'b0;
            end
        end
        chk("done_seen", done, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("busy_after_done", busy, 0);
    endtask

    task automatic verify(input string tag, input logic [1:0] dst);
        int bad;
        bad = 0;
        for (int k = 0; k < 96; k++)
            if (cap_img[16*k +: 16] !== 16'(k)) bad++;
        chk({tag, "_commits"}, ld_commits, 1);
        chk({tag, "_wbm_addr"}, cap_addr, dst);
        chk({tag, "_bad_words"}, bad, 0);
        chk({tag, "_addr_err"}, addr_err, 0);
        chk({tag, "_addr_stab"}, stab_err, 0);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wbm", bus.wbm, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic load, zero-wait memory
        run_load(16'h0100, 2'd2, 0, 0, 0, 0, cyc);
        verify("t1", 2'd2);
        chk("t1_latency", cyc, 194);
        chk("t1_addr_first", addr_log[0], 16'h0100);
        chk("t1_addr_last", addr_log[95], 16'h015F);
        chk("t1_commit_cycle", cap_t, 0);

        // 2: address wrap
        run_load(16'hFFF0, 2'd1, 0, 0, 0, 0, cyc);
        verify("t2", 2'd1);
        chk("t2_addr15", addr_log[15], 16'hFFFF);
        chk("t2_addr16", addr_log[16], 16'h0000);
        chk("t2_addr95", addr_log[95], 16'h004F);

        // 3: CPU holds the port for 5 cycles of COMMIT
        run_load(16'h0200, 2'd2, 0, 0, 1, 0, cyc);
        verify("t3", 2'd2);
        chk("t3_cpu_ok", cpu_ok, 5);
        chk("t3_cpu_bad", cpu_bad, 0);
        chk("t3_commit_cycle", cap_t, 5);
        chk("t3_wbm_cnt", wbm_cnt, 6);
        chk("t3_latency", cyc, 199);

        // 4: random handshake delays, dst 3 passed through
        run_load(16'h1234, 2'd3, 7, 7, 0, 0, cyc);
        verify("t4", 2'd3);

        // 5a: spurious starts are ignored
        run_load(16'h0100, 2'd2, 1, 1, 0, 1, cyc);
        verify("t5", 2'd2);

        // 5b: reset mid-load
        base_ref = 16'h0300; gnt_max = 0; rv_max = 0; cpu_hold_en = 0;
        clear_counts();
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0300; dst_bm = 2'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_mem_req", bus.mem_req, 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        chk("mid_rst_wbm", bus.wbm, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        #2;
        chk("mid_rst_no_wbm", wbm_cnt, 0);
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", busy, 0);

        run_load(16'h0400, 2'd0, 0, 0, 0, 0, cyc);
        verify("t5_recover", 2'd0);

`ifdef BM_LOAD_ABORT_EN
        // 6: abort in WAIT at word 40
        base_ref = 16'h0500; gnt_max = 0; rv_max = 0; cpu_hold_en = 0;
        clear_counts();
        abort_at = 40;
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0500; dst_bm = 2'd1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (aborted_cnt == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        #2;
        abort_at = -1;
        chk("t6_aborted", aborted_cnt, 1);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_wbm", wbm_cnt, 0);
        chk("t6_idle", busy, 0);
        chk("t6_grants", k_gnt, 41);
        chk("t6_rvalids", k_rv, 41);
        run_load(16'h0600, 2'd3, 0, 0, 0, 0, cyc);
        verify("t6_next", 2'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
